// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM encoding, register map, status bit layout.
// Imported by the receiver core; the status packer keeps bit placement in one spot.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 10;
  localparam int          TIMER_W              = 20;

  localparam logic [31:0] REG_DATA_OFS   = 32'h0000_0000;
  localparam logic [31:0] REG_STATUS_OFS = 32'h0000_0004;
  localparam int          ADDR_SEL_BIT   = 2;

  localparam int STAT_FULL = 0;
  localparam int STAT_FERR = 1;
  localparam int STAT_OVR  = 2;

  function automatic logic [31:0] status_word(input logic full,
                                              input logic ferr,
                                              input logic ovr);
    logic [31:0] w;
    w            = '0;
    w[STAT_FULL] = full;
    w[STAT_FERR] = ferr;
    w[STAT_OVR]  = ovr;
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; 2-cycle latency, no backpressure.
// Both stages load RESET_VAL on synchronous reset so the output is defined immediately.
module sync_2ff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with one-byte holding register and full/overrun/framing status.
// Bus reply is one cycle after accept; a held request is re-accepted every second cycle.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic        serialIn
);

  localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TIMER_W-1:0] FULL_LOAD = TIMER_W'(CLKS_PER_BIT - 1);

  rx_state_t          r_state;
  rx_state_t          w_state_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic [2:0]         r_bitcnt;
  logic [2:0]         w_bitcnt_nxt;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nxt;

  logic [7:0]         r_rx_data;
  logic               r_full;
  logic               r_ovr;
  logic               r_ferr;
  logic               r_rdy;
  logic [31:0]        r_rdata;

  logic               w_line;
  logic               w_tick;
  logic               w_deliver;
  logic               w_ferr_set;
  logic               w_accept;
  logic               w_is_write;
  logic               w_sel_status;
  logic               w_data_rd;
  logic               w_flag_clr;
  logic               w_store;
  logic               w_ovr_set;
  logic               w_unused;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (serialIn),
    .o_q   (w_line)
  );

  assign w_tick = (r_timer == '0);

  // ---------------- receive FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_deliver    = 1'b0;
    w_ferr_set   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_line) begin
          w_timer_nxt = HALF_LOAD;
          w_state_nxt = ST_START;
        end
      end

      ST_START: begin
        if (w_tick) begin
          // A line already back high at mid-start-bit is a glitch, not a frame
          if (!w_line) begin
            w_timer_nxt  = FULL_LOAD;
            w_bitcnt_nxt = '0;
            w_state_nxt  = ST_DATA;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_timer_nxt = r_timer - TIMER_W'(1);
        end
      end

      ST_DATA: begin
        if (w_tick) begin
          w_shift_nxt  = {w_line, r_shift[7:1]};
          w_timer_nxt  = FULL_LOAD;
          w_bitcnt_nxt = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            w_state_nxt = ST_STOP;
          end
        end else begin
          w_timer_nxt = r_timer - TIMER_W'(1);
        end
      end

      ST_STOP: begin
        if (w_tick) begin
          if (w_line) begin
            w_deliver   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_ferr_set  = 1'b1;
            w_state_nxt = ST_BREAK;
          end
        end else begin
          w_timer_nxt = r_timer - TIMER_W'(1);
        end
      end

      ST_BREAK: begin
        if (w_line) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------- bus side ----------------
  assign w_accept     = mem_valid & enable & ~r_rdy;
  assign w_is_write   = |mem_wstrb;
  assign w_sel_status = (mem_addr[ADDR_SEL_BIT] == REG_STATUS_OFS[ADDR_SEL_BIT]);
  assign w_data_rd    = w_accept & ~w_is_write & ~w_sel_status;
  assign w_flag_clr   = w_accept & mem_wstrb[0];

  // A DATA read landing on the delivery cycle frees the holding register in time for the new byte
  assign w_store      = w_deliver & (~r_full | w_data_rd);
  assign w_ovr_set    = w_deliver & r_full & ~w_data_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_data <= '0;
      r_full    <= 1'b0;
      r_ovr     <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      if (w_store) begin
        r_rx_data <= r_shift;
        r_full    <= 1'b1;
      end else if (w_data_rd) begin
        r_full <= 1'b0;
      end

      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (w_flag_clr) begin
        r_ovr <= 1'b0;
      end

      if (w_ferr_set) begin
        r_ferr <= 1'b1;
      end else if (w_flag_clr) begin
        r_ferr <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdy   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_rdy <= w_accept;
      if (w_accept) begin
        r_rdata <= w_sel_status ? status_word(r_full, r_ferr, r_ovr)
                                : {24'b0, r_rx_data};
      end
    end
  end

  assign mem_ready = enable ? r_rdy   : 1'bz;
  assign mem_rdata = enable ? r_rdata : 32'bz;

  assign w_unused = ^{mem_instr, mem_wdata, mem_addr[31:ADDR_SEL_BIT+1],
                      mem_addr[ADDR_SEL_BIT-1:0], mem_wstrb[3:1], REG_DATA_OFS};

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus randomized frames/bus traffic against a behavioural model.
module tb_uart_rx;

  localparam int CPB = 10;
  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_addr = 32'h0;
  logic        serialIn = 1'b1;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  logic       m_full, m_ovr, m_ferr;
  logic [7:0] m_data;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_instr (mem_instr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .serialIn  (serialIn)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on a negedge after the reply pulse has ended.
  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb,
                          output logic [31:0] rdata);
    int lat;
    lat       = 99;
    rdata     = 32'h0;
    mem_addr  = addr;
    mem_wstrb = strb;
    mem_wdata = {$urandom};
    mem_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        lat   = i;
        rdata = mem_rdata;
        break;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    check("bus_latency", lat, 1);
    @(negedge clk);
    check("ready_pulse", {31'b0, mem_ready}, 32'h0);
  endtask

  task automatic model_reset();
    m_full = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_data = 8'h00;
  endtask

  task automatic model_rx(input logic [7:0] b);
    if (!m_full) begin
      m_data = b;
      m_full = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic rd_status(input string tag);
    logic [31:0] v;
    bus_xfer(A_STAT, 4'h0, v);
    check(tag, v, {29'b0, m_ovr, m_ferr, m_full});
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] v;
    bus_xfer(A_DATA, 4'h0, v);
    check(tag, v, {24'b0, m_data});
    m_full = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] strb);
    logic [31:0] v;
    bus_xfer(addr, strb, v);
    if (strb[0]) begin
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
    end
  endtask

  // Bit index 0 = start, 1..8 = data LSB first, 9 = stop.  stop_low > 0 holds
  // the stop bit low for that many bit times; rst_bit pulses reset at that bit.
  task automatic send_frame(input logic [7:0] b, input int stop_low, input int rst_bit);
    logic [9:0] bits;
    int         len;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      len = CPB;
      serialIn = bits[k];
      if (k == 9 && stop_low > 0) begin
        serialIn = 1'b0;
        len      = CPB * stop_low;
      end
      for (int c = 0; c < len; c++) begin
        reset = (k == rst_bit) && (c < 2);
        @(negedge clk);
      end
    end
    reset = 1'b0;
    if (stop_low > 0) begin
      serialIn = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] v;
    int          cnt;
    int          op;
    logic [7:0]  b;
    logic [3:0]  strb;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, mem_ready}, 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    rd_status("rst_status");
    rd_data("rst_data");

    // Single byte
    send_frame(8'hA5, 0, -1); model_rx(8'hA5);
    rd_status("a5_status_full");
    rd_data("a5_data");
    rd_status("a5_status_empty");

    // Overrun
    send_frame(8'h11, 0, -1); model_rx(8'h11);
    send_frame(8'h22, 0, -1); model_rx(8'h22);
    rd_data("ovr_data_first");
    rd_status("ovr_status");
    wr(A_STAT, 4'h1);
    rd_status("ovr_cleared");

    // Framing error then a good byte
    send_frame(8'h3C, 2, -1); m_ferr = 1'b1;
    rd_status("ferr_status");
    send_frame(8'h7E, 0, -1); model_rx(8'h7E);
    rd_status("ferr_then_full");
    rd_data("after_ferr_data");
    wr(A_DATA, 4'hF);
    rd_status("ferr_cleared");

    // Short glitch on idle line
    serialIn = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    serialIn = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    rd_status("glitch_status");
    send_frame(8'hC3, 0, -1); model_rx(8'hC3);
    rd_data("post_glitch_data");

    // Reset during data bit 4 of 0xFF
    send_frame(8'hFF, 0, 5); model_reset();
    repeat (CPB) @(negedge clk);
    rd_status("midrst_status");
    send_frame(8'h5A, 0, -1); model_rx(8'h5A);
    rd_status("midrst_full");
    rd_data("midrst_data");
    rd_status("midrst_empty");

    // DATA read accepted on the delivery cycle.  Start bit driven on negedge N0 is
    // seen by the FSM in cycle 0 ending at edge 3; stop sample ends at edge 3+95=98,
    // so the request must be raised on negedge 97.
    send_frame(8'h42, 0, -1); model_rx(8'h42);
    fork
      send_frame(8'h99, 0, -1);
      begin
        repeat (97) @(negedge clk);
        bus_xfer(A_DATA, 4'h0, v);
        check("collide_old_byte", v, 32'h42);
      end
    join
    m_data = 8'h99; m_full = 1'b1;
    rd_status("collide_status");
    rd_data("collide_new_byte");
    rd_status("collide_empty");

    // Held request: accepts alternate cycles
    cnt       = 0;
    mem_addr  = A_STAT;
    mem_wstrb = 4'h0;
    mem_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mem_ready === 1'b1) cnt++;
    end
    mem_valid = 1'b0;
    @(negedge clk);
    check("held_valid_pulses", cnt, 2);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 6);
      b  = 8'($urandom);
      case (op)
        0, 1, 2: begin
          send_frame(b, 0, -1);
          model_rx(b);
        end
        3: begin
          send_frame(b, $urandom_range(1, 2), -1);
          m_ferr = 1'b1;
        end
        4: rd_data("rand_data");
        5: rd_status("rand_status");
        default: begin
          strb = 4'($urandom_range(1, 15));
          wr(($urandom_range(0, 1) != 0) ? A_STAT : A_DATA, strb);
        end
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rd_status("final_status");
    rd_data("final_data");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Memory-mapped UART receiver; the receive-side counterpart of the UART transmitter on the same picorv32-style bus. Oversamples `serialIn` with a fixed clock-per-bit divider and deframes 8N1 characters, LSB first. Holds one received byte with full, overrun and framing-error status for polling by the CPU. Default bit period equals the transmitter's, so the two loop back directly in simulation.

## Interface
- `CLKS_PER_BIT`, default 10: clocks per serial bit; 434 gives 115200 baud at 50 MHz; legal range 4..2^20-1.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  address-decode select for this block.
- `mem_valid`  in  1  bus request.
- `mem_ready`  out  1  bus acknowledge, one cycle; high-Z when `enable` is low.
- `mem_instr`  in  1  ignored.
- `mem_wstrb`  in  4  write strobes; all zero means read.
- `mem_wdata`  in  32  write data; ignored except as a clear trigger.
- `mem_addr`  in  32  bit 2 selects the register (0 = DATA, 1 = STATUS).
- `mem_rdata`  out  32  registered read data; high-Z when `enable` is low.
- `serialIn`  in  1  asynchronous serial line; idle high.

## Operation
- Input: 2-flop synchronizer on `serialIn`. Reset loads the synchronizer with 1.
- FSM states are IDLE, START, DATA, STOP and BREAK. Bit timer is 20 bits and counts down. Bit counter is 3 bits.
  - IDLE: when the synchronized line is 0, load the timer with CLKS_PER_BIT/2 - 1 (integer division) and go to START.
  - START: on timer 0, sample the line. If it is 0, load CLKS_PER_BIT-1 and go to DATA with bit count 0. If it is 1, treat it as a glitch and return to IDLE with no flag set.
  - DATA: on each timer 0, shift the sample into bit 7 of the shifter (right shift) and reload the timer. After the 8th sample go to STOP.
  - STOP: on timer 0, sample the line.
    - Sample is 1: deliver the byte and go to IDLE.
    - Sample is 0: set `framingErr`, discard the byte and go to BREAK.
  - BREAK: wait until the line is 1, then go to IDLE.
- Delivery:
  - If `full` is 0: `rxData` <= shifter, `full` <= 1.
  - If `full` is 1: set `overrun`; `rxData` keeps the old byte.
- Bus accept: `accept = mem_valid & enable & ~rdy`. On accept, `rdy` <= 1 for exactly one cycle and `mem_rdata` <= the selected register.
  - DATA read: returns {24'b0, rxData} and clears `full`.
  - STATUS read: returns {29'b0, overrun, framingErr, full}. No side effects.
  - Any write with `mem_wstrb[0]` set, to either address: clears `overrun` and `framingErr`. Writes never change `rxData` or `full`.
- Read of DATA and delivery in the same cycle:
  - `mem_rdata` returns the old byte.
  - The new byte is stored and `full` stays 1.
  - No overrun is raised.
- Set and clear of `overrun` or `framingErr` in the same cycle: set wins.

## Timing
- Reset values:
  - `rdy`, `mem_ready` = 0; `mem_rdata` = 0.
  - `rxData` = 0; `full`, `overrun`, `framingErr` = 0.
  - FSM = IDLE; all timers and counters = 0.
- The FSM sees the line 2 cycles after a change on `serialIn`.
- Relative to the cycle IDLE detects 0, call the sample points S = CLKS_PER_BIT/2 + k·CLKS_PER_BIT, with k = 0 for start, 1..8 for data, 9 for stop.
- `full` rises on the edge after the stop sample.
- Bus latency: `mem_ready` is high exactly on the cycle after accept, with `mem_rdata` valid in that cycle. A held `mem_valid` produces a new accept every second cycle.
- Reset asserted mid-character abandons the frame with no flags set. After reset the FSM waits in IDLE for a falling edge; it does not resynchronize mid-frame.
- Back-to-back frames are accepted: a start bit immediately following the stop sample is detected.

## Structure
- Shared package/header `uart_pkg`:
  - FSM state encoding.
  - DATA/STATUS offsets.
  - STATUS bit positions (FULL = 0, FERR = 1, OVR = 2).
  - Default CLKS_PER_BIT.
- Sub-module `sync_2ff`: generic 2-flop synchronizer with a reset value parameter, reusable by other asynchronous inputs.
- Everything else lives in `uart_rx`.

## Test plan
- Loopback from the transmitter, byte 0xA5:
  - STATUS reads 0x1.
  - DATA reads 0x000000A5.
  - STATUS then reads 0x0.
- Send 0x11 then 0x22 without reading:
  - DATA reads 0x11.
  - STATUS reads 0x4 (overrun set).
  - After a write to STATUS, STATUS reads 0x0.
- Frame 0x3C with the stop bit held low for 2 bit times:
  - STATUS reads 0x2 and `full` stays 0.
  - The following valid 0x7E is received normally.
- Low glitch of CLKS_PER_BIT/4 cycles on an idle line: no byte and no flags; FSM back in IDLE.
- Reset asserted at data bit 4 of 0xFF, then 0x5A sent: only 0x5A is received, and all flags are 0.
- DATA read accepted on the exact delivery cycle of 0x99 while 0x42 is held:
  - The read returns 0x42.
  - `full` = 1 and the next DATA read returns 0x99.
  - `overrun` = 0.
